sign_extend_unit: RTL and testbench

- Immediate-extension block for the MIPS datapath, located between instruction decode and the ALU/branch-address operand muxes.
- Takes the 16-bit instruction immediate and produces a 32-bit operand.
- The default mode is two's-complement sign extension; zero-extend, LUI, byte and branch-offset forms are selectable.
- Output is registered: one-cycle latency, with a valid flag.

---
 rtl/sign_extend_unit_pkg.sv | 19 +
 rtl/sign_extend_unit_core.sv | 39 +++
 rtl/sign_extend_unit.sv | 46 ++++
 tb/tb_sign_extend_unit.sv | 131 +++++++++++++
 4 files changed

// File: rtl/sign_extend_unit_pkg.sv
// Shared constants and mode encodings for the MIPS immediate extender.
package sign_extend_unit_pkg;

    localparam int IMM_W_DEF  = 16;
    localparam int DATA_W_DEF = 32;
    localparam int BYTE_W     = 8;

    typedef enum logic [2:0] {
        MODE_SEXT16 = 3'd0,
        MODE_ZEXT16 = 3'd1,
        MODE_LUI    = 3'd2,
        MODE_SEXT8  = 3'd3,
        MODE_ZEXT8  = 3'd4,
        MODE_BROFF  = 3'd5,
        MODE_RSVD6  = 3'd6,
        MODE_RSVD7  = 3'd7
    } ext_mode_t;

endpackage

// File: rtl/sign_extend_unit_core.sv
// Purely combinational immediate/data extender; reusable for load byte/half data.
module sign_extend_unit_core
    import sign_extend_unit_pkg::*;
#(
    parameter int IMM_W  = IMM_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [IMM_W-1:0]  value,
    input  ext_mode_t         mode,
    output logic [DATA_W-1:0] result,
    output logic              err
);

    logic [DATA_W-1:0] sext_full;
    logic [DATA_W-1:0] zext_full;
    logic [DATA_W-1:0] sext_byte;
    logic [DATA_W-1:0] zext_byte;

    assign sext_full = {{(DATA_W-IMM_W){value[IMM_W-1]}}, value};
    assign zext_full = {{(DATA_W-IMM_W){1'b0}}, value};
    assign sext_byte = {{(DATA_W-BYTE_W){value[BYTE_W-1]}}, value[BYTE_W-1:0]};
    assign zext_byte = {{(DATA_W-BYTE_W){1'b0}}, value[BYTE_W-1:0]};

    always_comb begin
        result = '0;
        err    = 1'b0;
        case (mode)
            MODE_SEXT16: result = sext_full;
            MODE_ZEXT16: result = zext_full;
            // Immediate lands in the upper half; low bits are zero-filled.
            MODE_LUI:    result = zext_full << (DATA_W - IMM_W);
            MODE_SEXT8:  result = sext_byte;
            MODE_ZEXT8:  result = zext_byte;
            MODE_BROFF:  result = sext_full << 2;
            default:     err    = 1'b1;
        endcase
    end

endmodule

// File: rtl/sign_extend_unit.sv
// Registered immediate extender: one-cycle latency, valid flag, sync reset.
module sign_extend_unit
    import sign_extend_unit_pkg::*;
#(
    parameter int IMM_W  = IMM_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [IMM_W-1:0]  value,
    input  logic [2:0]        mode,
    output logic [DATA_W-1:0] sign_extended_value,
    output logic              out_valid,
    output logic              mode_err
);

    logic [DATA_W-1:0] core_result;
    logic              core_err;

    sign_extend_unit_core #(
        .IMM_W  (IMM_W),
        .DATA_W (DATA_W)
    ) u_core (
        .value  (value),
        .mode   (ext_mode_t'(mode)),
        .result (core_result),
        .err    (core_err)
    );

    // Result and error hold across idle cycles; only the valid flag drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_extended_value <= '0;
            out_valid           <= 1'b0;
            mode_err            <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sign_extended_value <= core_result;
                mode_err            <= core_err;
            end
        end
    end

endmodule

// File: tb/tb_sign_extend_unit.sv
// Directed scoreboard bench for sign_extend_unit.
module tb_sign_extend_unit;
    import sign_extend_unit_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] value;
    logic [2:0]  mode;
    logic [31:0] sign_extended_value;
    logic        out_valid;
    logic        mode_err;

    int checks   = 0;
    int failures = 0;

    exp_t        sb[$];
    logic [31:0] hold_data;
    logic        hold_err;

    sign_extend_unit dut (
        .clk                 (clk),
        .rst                 (rst),
        .in_valid            (in_valid),
        .value               (value),
        .mode                (mode),
        .sign_extended_value (sign_extended_value),
        .out_valid           (out_valid),
        .mode_err            (mode_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle; push the expectation, then compare just after the edge.
    task automatic step(input string tag, input logic r, input logic iv,
                        input logic [15:0] v, input logic [2:0] m,
                        input logic [31:0] exp_data, input logic exp_err);
        exp_t e;
        rst      = r;
        in_valid = iv;
        value    = v;
        mode     = m;
        if (iv && !r) begin
            e.data = exp_data;
            e.err  = exp_err;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (r) begin
            sb.delete();
            hold_data = 32'h0;
            hold_err  = 1'b0;
            chk({tag, ".valid"}, {31'h0, out_valid}, 32'h0);
            chk({tag, ".data"},  sign_extended_value, 32'h0);
            chk({tag, ".err"},   {31'h0, mode_err}, 32'h0);
        end else if (sb.size() != 0) begin
            e = sb.pop_front();
            hold_data = e.data;
            hold_err  = e.err;
            chk({tag, ".valid"}, {31'h0, out_valid}, 32'h1);
            chk({tag, ".data"},  sign_extended_value, e.data);
            chk({tag, ".err"},   {31'h0, mode_err}, {31'h0, e.err});
        end else begin
            chk({tag, ".valid"}, {31'h0, out_valid}, 32'h0);
            chk({tag, ".hold"},  sign_extended_value, hold_data);
            chk({tag, ".herr"},  {31'h0, mode_err}, {31'h0, hold_err});
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; value = 16'h8000; mode = MODE_SEXT16;
        hold_data = 32'h0; hold_err = 1'b0;

        step("rst0", 1, 1, 16'h8000, MODE_SEXT16, 32'h0, 0);
        step("rst1", 1, 1, 16'h8000, MODE_SEXT16, 32'h0, 0);

        step("sx_0000", 0, 1, 16'h0000, MODE_SEXT16, 32'h00000000, 0);
        step("sx_8000", 0, 1, 16'h8000, MODE_SEXT16, 32'hFFFF8000, 0);
        step("sx_7fff", 0, 1, 16'h7FFF, MODE_SEXT16, 32'h00007FFF, 0);
        step("sx_ffff", 0, 1, 16'hFFFF, MODE_SEXT16, 32'hFFFFFFFF, 0);
        step("zx_ffff", 0, 1, 16'hFFFF, MODE_ZEXT16, 32'h0000FFFF, 0);

        step("zx16",  0, 1, 16'h8081, MODE_ZEXT16, 32'h00008081, 0);
        step("lui",   0, 1, 16'h8081, MODE_LUI,    32'h80810000, 0);
        step("sx8",   0, 1, 16'h8081, MODE_SEXT8,  32'hFFFFFF81, 0);
        step("zx8",   0, 1, 16'h8081, MODE_ZEXT8,  32'h00000081, 0);
        step("broff", 0, 1, 16'h8081, MODE_BROFF,  32'hFFFE0204, 0);
        step("sx8_hi",  0, 1, 16'hFF7F, MODE_SEXT8,  32'h0000007F, 0);
        step("broff_p", 0, 1, 16'h0003, MODE_BROFF,  32'h0000000C, 0);

        step("rsvd6",   0, 1, 16'h1234, 3'd6,        32'h00000000, 1);
        step("rsvd_id", 0, 0, 16'h5555, MODE_SEXT16, 32'h0, 0);
        step("clr_err", 0, 1, 16'h0001, MODE_SEXT16, 32'h00000001, 0);
        step("rsvd7",   0, 1, 16'hABCD, 3'd7,        32'h00000000, 1);

        step("gap_in",  0, 1, 16'h0005, MODE_SEXT16, 32'h00000005, 0);
        step("gap1",    0, 0, 16'hFFFF, MODE_LUI,    32'h0, 0);
        step("gap2",    0, 0, 16'h8000, MODE_SEXT16, 32'h0, 0);
        step("gap3",    0, 0, 16'h1234, 3'd6,        32'h0, 0);

        step("mid_a",   0, 1, 16'h1111, MODE_SEXT16, 32'h00001111, 0);
        step("mid_rst", 1, 1, 16'h2222, MODE_SEXT16, 32'h0, 0);
        step("post",    0, 1, 16'hFFFE, MODE_SEXT16, 32'hFFFFFFFE, 0);
        step("post_id", 0, 0, 16'h0000, MODE_SEXT16, 32'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
